cube: RTL and testbench

//  Inverse companion to the cube-root unit: computes res = x^3 for an unsigned x.

---
 rtl/cube_pkg.sv | 13 +
 rtl/cube.sv | 121 ++++++++++++
 tb/tb_cube.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cube_pkg.sv
// cube_pkg: shared FSM state encoding and default widths for the cube unit and its bench.
package cube_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CU   = 2'd2
    } state_t;

    localparam int CUBE_IN_W  = 4;
    localparam int CUBE_RES_W = 12;

endpackage

// File: rtl/cube.sv
// cube: res = x^3 by shift-and-add over an external shared adder, one add per cycle.
//   Ports: clk, rst (sync, active-high), x (operand, sampled on start edge),
//          start (honoured only while busy=0), res (cube, held until next job completes),
//          busy (job in progress), sum_a/sum_b (adder operands out), sum_out (adder result in).
//   Optional macro CUBE_EARLY_EXIT_EN: each phase stops at the highest set bit of x,
//   and x==0 completes after a single busy cycle.
module cube
    import cube_pkg::*;
#(
    parameter int IN_W  = CUBE_IN_W,
    parameter int RES_W = CUBE_RES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  x,
    input  logic             start,
    output logic [RES_W-1:0] res,
    output logic             busy,
    output logic [RES_W-1:0] sum_a,
    output logic [RES_W-1:0] sum_b,
    input  logic [RES_W-1:0] sum_out
);

    localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_W - 1);

    state_t             state_q, state_d;
    logic [IN_W-1:0]    xr_q, xr_d;
    logic [RES_W-1:0]   op_q, op_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               busy_q, busy_d;
    logic               last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xr_q    <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
        end
    end

    // Partial product for bit idx of the multiplier: op shifted into place, or nothing.
    assign sum_a = (state_q == IDLE) ? '0 : acc_q;
    assign sum_b = (state_q != IDLE && xr_q[idx_q]) ? (op_q << idx_q) : '0;

`ifdef CUBE_EARLY_EXIT_EN
    // Phase ends once no multiplier bit above idx remains set.
    assign last = ((xr_q >> idx_q) >> 1) == '0;
`else
    assign last = idx_q == IDX_LAST;
`endif

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        op_d    = op_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        res_d   = res_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d    = x;
                    op_d    = RES_W'(x);
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SQ;
                end
            end
            SQ: begin
                acc_d = sum_out;
                idx_d = idx_q + 1'b1;
                if (last) begin
                    op_d    = sum_out;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = CU;
                end
`ifdef CUBE_EARLY_EXIT_EN
                // Zero operand: the cube is already known, skip the second phase.
                if (xr_q == '0) begin
                    res_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`endif
            end
            CU: begin
                acc_d = sum_out;
                idx_d = idx_q + 1'b1;
                if (last) begin
                    res_d   = sum_out;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res  = res_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_cube.sv
// tb_cube: directed self-checking bench for cube with a 12-bit adder wired to sum_*.
module tb_cube;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  x;
    logic [11:0] res;
    logic        busy;
    logic [11:0] sum_a;
    logic [11:0] sum_b;
    logic [11:0] sum_out;
    int          vectors = 0;
    int          miscompares = 0;

    cube #(.IN_W(4), .RES_W(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .start   (start),
        .res     (res),
        .busy    (busy),
        .sum_a   (sum_a),
        .sum_b   (sum_b),
        .sum_out (sum_out)
    );

    assign sum_out = sum_a + sum_b;

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [3:0] v);
`ifdef CUBE_EARLY_EXIT_EN
        int m;
        m = -1;
        for (int i = 0; i < 4; i++) if (v[i]) m = i;
        return (v == 4'd0) ? 1 : 2 * (m + 1);
`else
        return 8;
`endif
    endfunction

    task automatic start_job(input logic [3:0] xv);
        @(negedge clk);
        x = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int bc);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        x = 4'd15;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++;
        if (res !== 12'd0) begin miscompares++; $display("FAIL reset_res got %0d want 0", res); end
        vectors++;
        if (sum_a !== 12'd0 || sum_b !== 12'd0) begin
            miscompares++; $display("FAIL reset_sum got a=%0d b=%0d want 0/0", sum_a, sum_b);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int bc;
        @(negedge clk);
        x = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            if (bc == 1) begin
                vectors++;
                if (sum_a !== 12'd0 || sum_b !== 12'd3) begin
                    miscompares++; $display("FAIL sq_cycle1 got a=%0d b=%0d want 0/3", sum_a, sum_b);
                end
            end
            if (bc == 2) begin
                vectors++;
                if (sum_a !== 12'd3 || sum_b !== 12'd6) begin
                    miscompares++; $display("FAIL sq_cycle2 got a=%0d b=%0d want 3/6", sum_a, sum_b);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (bc !== exp_lat(4'd3)) begin miscompares++; $display("FAIL lat_x3 got %0d want %0d", bc, exp_lat(4'd3)); end
        vectors++;
        if (res !== 12'd27) begin miscompares++; $display("FAIL res_x3 got %0d want 27", res); end
        start_job(4'd15);
        wait_done(bc);
        vectors++;
        if (bc !== exp_lat(4'd15)) begin miscompares++; $display("FAIL lat_x15 got %0d want %0d", bc, exp_lat(4'd15)); end
        vectors++;
        if (res !== 12'd3375) begin miscompares++; $display("FAIL res_x15 got %0d want 3375", res); end
        start_job(4'd0);
        wait_done(bc);
        vectors++;
        if (bc !== exp_lat(4'd0)) begin miscompares++; $display("FAIL lat_x0 got %0d want %0d", bc, exp_lat(4'd0)); end
        vectors++;
        if (res !== 12'd0) begin miscompares++; $display("FAIL res_x0 got %0d want 0", res); end
    endtask

    task automatic test_back_to_back;
        int bc;
        logic [11:0] e;
        start = 1'b1;
        for (int v = 0; v < 16; v++) begin
            x = 4'(v);
            @(negedge clk);
            wait_done(bc);
            e = 12'(v * v * v);
            vectors++;
            if (bc !== exp_lat(4'(v))) begin
                miscompares++; $display("FAIL b2b_lat x=%0d got %0d want %0d", v, bc, exp_lat(4'(v)));
            end
            vectors++;
            if (res !== e) begin miscompares++; $display("FAIL b2b_res x=%0d got %0d want %0d", v, res, e); end
        end
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_stop got busy=%0b want 0", busy); end
    endtask

    task automatic test_ignore_start;
        int bc;
        @(negedge clk);
        x = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            if (bc == 2) begin x = 4'd9; start = 1'b1; end
            if (bc == 3) start = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (bc !== exp_lat(4'd5)) begin miscompares++; $display("FAIL ign_lat got %0d want %0d", bc, exp_lat(4'd5)); end
        vectors++;
        if (res !== 12'd125) begin miscompares++; $display("FAIL ign_res got %0d want 125", res); end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || res !== 12'd125) begin
            miscompares++; $display("FAIL ign_hold got busy=%0b res=%0d want 0/125", busy, res);
        end
    endtask

    task automatic test_reset_mid;
        int bc;
        start_job(4'd7);
        bc = 1;
        while (busy && bc < 4) begin
            bc++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || res !== 12'd0) begin
            miscompares++; $display("FAIL mid_rst got busy=%0b res=%0d want 0/0", busy, res);
        end
        start_job(4'd2);
        wait_done(bc);
        vectors++;
        if (bc !== exp_lat(4'd2)) begin miscompares++; $display("FAIL post_rst_lat got %0d want %0d", bc, exp_lat(4'd2)); end
        vectors++;
        if (res !== 12'd8) begin miscompares++; $display("FAIL post_rst_res got %0d want 8", res); end
    endtask

    task automatic test_latency;
        int bc;
        logic [3:0]  xs [3] = '{4'd1, 4'd5, 4'd8};
        logic [11:0] cs [3] = '{12'd1, 12'd125, 12'd512};
`ifdef CUBE_EARLY_EXIT_EN
        int ls [3] = '{2, 6, 8};
`else
        int ls [3] = '{8, 8, 8};
`endif
        for (int i = 0; i < 3; i++) begin
            start_job(xs[i]);
            wait_done(bc);
            vectors++;
            if (bc !== ls[i]) begin miscompares++; $display("FAIL lat x=%0d got %0d want %0d", xs[i], bc, ls[i]); end
            vectors++;
            if (res !== cs[i]) begin miscompares++; $display("FAIL res x=%0d got %0d want %0d", xs[i], res, cs[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        x = 4'd0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        test_latency;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
